// File: rtl/uart_io_fifo_pkg.sv
// Shared register map and status word layout for the J1 UART I/O bridge.
// Mirrors the UartAddr* and St* constants kept in define.v.
package uart_io_fifo_pkg;

    localparam logic UART_ADDR_DATA = 1'b0;
    localparam logic UART_ADDR_STAT = 1'b1;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_SPACE = 1;
    localparam int ST_RX_OVF   = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_TX_IDLE  = 4;
    localparam int ST_W        = 5;

    // Field order is MSB first, so rx_avail lands on bit 0.
    typedef struct packed {
        logic tx_idle;
        logic tx_ovf;
        logic rx_ovf;
        logic tx_space;
        logic rx_avail;
    } status_t;

endpackage

// File: rtl/uart_io_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop on a full FIFO frees the slot
// that a same-cycle push then fills, so both succeed.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Empty reads as zero so the head output never shows stale storage.
    assign dout = empty ? '0 : mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; contents are only visible
    // through dout when count says they are valid, and this keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_io_fifo.sv
// J1 CPU <-> UART byte bridge: RX and TX FIFOs behind a two-register map
// (addr 0 data, addr 1 status / write-1-to-clear sticky flags).
module uart_io_fifo
    import uart_io_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              irq_rx
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] rx_head;
    logic              rx_full, rx_empty, rx_pop;
    logic [AW:0]       rx_count;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic [AW:0]       tx_count;
    logic              rx_ovf, tx_ovf;
    logic              rx_ovf_set, tx_ovf_set, rx_ovf_clr, tx_ovf_clr;
    status_t           status;
    logic [DATA_W-1:0] rd_data;

    assign rx_pop  = cpu_rd && (cpu_addr == UART_ADDR_DATA) && !rx_empty;
    assign tx_push = cpu_wr && (cpu_addr == UART_ADDR_DATA);
    assign tx_pop  = tx_valid && tx_ready;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_valid),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (cpu_din),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_valid = !tx_empty;
    assign irq_rx   = !rx_empty;

    // A byte is lost only when the FIFO is full and nothing leaves it this cycle.
    assign rx_ovf_set = rx_valid && rx_full && !rx_pop;
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;
    assign rx_ovf_clr = cpu_wr && (cpu_addr == UART_ADDR_STAT) && cpu_din[ST_RX_OVF];
    assign tx_ovf_clr = cpu_wr && (cpu_addr == UART_ADDR_STAT) && cpu_din[ST_TX_OVF];

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        status          = '0;
        status.rx_avail = !rx_empty;
        status.tx_space = !tx_full;
        status.rx_ovf   = rx_ovf;
        status.tx_ovf   = tx_ovf;
        status.tx_idle  = tx_empty;

        rd_data = '0;
        if (cpu_addr == UART_ADDR_STAT)
            rd_data = {{(DATA_W-ST_W){1'b0}}, status};
        else if (!rx_empty)
            rd_data = rx_head;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_dout <= '0;
            rx_ovf   <= 1'b0;
            tx_ovf   <= 1'b0;
        end else begin
            if (cpu_rd) cpu_dout <= rd_data;
            // Set has priority over a same-cycle write-1-to-clear.
            if (rx_ovf_set)      rx_ovf <= 1'b1;
            else if (rx_ovf_clr) rx_ovf <= 1'b0;
            if (tx_ovf_set)      tx_ovf <= 1'b1;
            else if (tx_ovf_clr) tx_ovf <= 1'b0;
        end
    end

    count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        (rx_count <= DEPTH_CNT) && (tx_count <= DEPTH_CNT));

endmodule

// File: tb/tb_uart_io_fifo.sv
// Scoreboard bench for uart_io_fifo: expected RX/TX bytes are queued when
// stimulus is driven and compared as the CPU reads or the TX side drains.
module tb_uart_io_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_addr = 1'b0;
    logic [7:0] cpu_din = '0, cpu_dout;
    logic [7:0] rx_data = '0, tx_data;
    logic       rx_valid = 1'b0, tx_valid, tx_ready = 1'b0, irq_rx;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    uart_io_fifo #(.DATA_W(8), .DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq_rx   (irq_rx)
    );

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic cpu_read(input logic a, output logic [7:0] d);
        @(negedge clk); cpu_rd = 1'b1; cpu_addr = a;
        @(negedge clk); cpu_rd = 1'b0; d = cpu_dout;
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] v);
        @(negedge clk); cpu_wr = 1'b1; cpu_addr = a; cpu_din = v;
        @(negedge clk); cpu_wr = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        n_checks++; if (cpu_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h want=00", cpu_dout); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        n_checks++; if (irq_rx !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b want=0", irq_rx); end
        @(negedge clk); rst_n = 1'b1;
        cpu_read(1'b1, d);
        n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL reset_status got=%h want=12", d); end
    endtask

    task automatic test_rx_basic();
        logic [7:0] d, exp;
        rx_q.push_back(8'h41); rx_push(8'h41);
        n_checks++; if (irq_rx !== 1'b1) begin n_fail++; $display("FAIL rx_irq_latency got=%b want=1", irq_rx); end
        rx_q.push_back(8'h42); rx_push(8'h42);
        for (int i = 0; i < 2; i++) begin
            cpu_read(1'b0, d);
            exp = rx_q.pop_front();
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL rx_basic_data[%0d] got=%h want=%h", i, d, exp); end
        end
        cpu_read(1'b0, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rx_empty_read got=%h want=00", d); end
        cpu_read(1'b1, d);
        n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL rx_empty_status got=%h want=12", d); end
        n_checks++; if (irq_rx !== 1'b0) begin n_fail++; $display("FAIL rx_empty_irq got=%b want=0", irq_rx); end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] d, exp;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) rx_q.push_back(8'(i));
            rx_push(8'(i));
        end
        cpu_read(1'b1, d);
        n_checks++; if (d !== 8'h17) begin n_fail++; $display("FAIL rx_ovf_status got=%h want=17", d); end
        for (int i = 0; i < 16; i++) begin
            cpu_read(1'b0, d);
            exp = rx_q.pop_front();
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL rx_ovf_data[%0d] got=%h want=%h", i, d, exp); end
        end
        cpu_write(1'b1, 8'h04);
        cpu_read(1'b1, d);
        n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL rx_ovf_clear got=%h want=12", d); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] d, exp;
        int         drained;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tx_q.push_back(8'h30 + 8'(i));
            cpu_write(1'b0, 8'h30 + 8'(i));
        end
        cpu_write(1'b0, 8'h40);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h30) begin n_fail++; $display("FAIL tx_hold got=%b/%h want=1/30", tx_valid, tx_data); end
        cpu_read(1'b1, d);
        n_checks++; if (d !== 8'h08) begin n_fail++; $display("FAIL tx_full_status got=%h want=08", d); end
        @(negedge clk); tx_ready = 1'b1;
        drained = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_valid) begin
                exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
                n_checks++; if (tx_data !== exp) begin n_fail++; $display("FAIL tx_drain[%0d] got=%h want=%h", drained, tx_data, exp); end
                drained++;
            end else if (tx_q.size() == 0) begin
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (tx_q.size() != 0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drain_done got=%0d_left/%b want=0_left/0", tx_q.size(), tx_valid); end
        // Read and clear in the same cycle: the read sees the pre-clear flag.
        @(negedge clk); cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 1'b1; cpu_din = 8'h08;
        @(negedge clk); cpu_rd = 1'b0; cpu_wr = 1'b0;
        n_checks++; if (cpu_dout !== 8'h1A) begin n_fail++; $display("FAIL tx_idle_status got=%h want=1a", cpu_dout); end
        cpu_read(1'b1, d);
        n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL tx_ovf_clear got=%h want=12", d); end
    endtask

    task automatic test_rx_full_pushpop();
        logic [7:0] d, exp;
        for (int i = 0; i < 16; i++) begin
            rx_q.push_back(8'h60 + 8'(i));
            rx_push(8'h60 + 8'(i));
        end
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h55; cpu_rd = 1'b1; cpu_addr = 1'b0;
        @(negedge clk); rx_valid = 1'b0; cpu_rd = 1'b0;
        exp = rx_q.pop_front();
        rx_q.push_back(8'h55);
        n_checks++; if (cpu_dout !== exp) begin n_fail++; $display("FAIL pushpop_read got=%h want=%h", cpu_dout, exp); end
        cpu_read(1'b1, d);
        n_checks++; if (d !== 8'h13) begin n_fail++; $display("FAIL pushpop_no_ovf got=%h want=13", d); end
        for (int i = 0; i < 16; i++) begin
            cpu_read(1'b0, d);
            exp = rx_q.pop_front();
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL pushpop_data[%0d] got=%h want=%h", i, d, exp); end
        end
        cpu_read(1'b1, d);
        n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL pushpop_empty got=%h want=12", d); end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        tx_ready = 1'b0;
        cpu_write(1'b0, 8'h77);
        cpu_write(1'b0, 8'h78);
        rx_push(8'h99);
        cpu_read(1'b1, d);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin n_fail++; $display("FAIL mid_tx_before got=%b/%h want=1/77", tx_valid, tx_data); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_async got=%b/%h want=0/00", tx_valid, tx_data); end
        n_checks++; if (cpu_dout !== 8'h00 || irq_rx !== 1'b0) begin n_fail++; $display("FAIL mid_tx_outputs got=%h/%b want=00/0", cpu_dout, irq_rx); end
        @(negedge clk); rst_n = 1'b1;
        tx_q.delete(); rx_q.delete();
        cpu_read(1'b1, d);
        n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL mid_tx_status got=%h want=12", d); end
        cpu_read(1'b0, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL mid_tx_rx_flushed got=%h want=00", d); end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_rx_overflow();
        test_tx_overflow();
        test_rx_full_pushpop();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
